// File: rtl/inv_sub_bytes.sv
// Sequential AES InvSubBytes engine: one 128-bit state in, one 32-bit column
// substituted per cycle through the inverse S-box, result out on a handshake.
module inv_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        col_r;
  logic [LENGTH-1:0] st_r;
  logic [DWORD-1:0]  col_in_s;
  logic [DWORD-1:0]  col_sub_s;
  logic [LENGTH-1:0] st_next_s;

  // Inverse of the FIPS-197 forward S-box, every one of the 256 codes listed.
  function automatic logic [BYTE-1:0] inv_sbox(input logic [BYTE-1:0] x);
    case (x)
      8'h00: inv_sbox = 8'h52;
      8'h01: inv_sbox = 8'h09;
      8'h02: inv_sbox = 8'h6a;
      8'h03: inv_sbox = 8'hd5;
      8'h04: inv_sbox = 8'h30;
      8'h05: inv_sbox = 8'h36;
      8'h06: inv_sbox = 8'ha5;
      8'h07: inv_sbox = 8'h38;
      8'h08: inv_sbox = 8'hbf;
      8'h09: inv_sbox = 8'h40;
      8'h0a: inv_sbox = 8'ha3;
      8'h0b: inv_sbox = 8'h9e;
      8'h0c: inv_sbox = 8'h81;
      8'h0d: inv_sbox = 8'hf3;
      8'h0e: inv_sbox = 8'hd7;
      8'h0f: inv_sbox = 8'hfb;
      8'h10: inv_sbox = 8'h7c;
      8'h11: inv_sbox = 8'he3;
      8'h12: inv_sbox = 8'h39;
      8'h13: inv_sbox = 8'h82;
      8'h14: inv_sbox = 8'h9b;
      8'h15: inv_sbox = 8'h2f;
      8'h16: inv_sbox = 8'hff;
      8'h17: inv_sbox = 8'h87;
      8'h18: inv_sbox = 8'h34;
      8'h19: inv_sbox = 8'h8e;
      8'h1a: inv_sbox = 8'h43;
      8'h1b: inv_sbox = 8'h44;
      8'h1c: inv_sbox = 8'hc4;
      8'h1d: inv_sbox = 8'hde;
      8'h1e: inv_sbox = 8'he9;
      8'h1f: inv_sbox = 8'hcb;
      8'h20: inv_sbox = 8'h54;
      8'h21: inv_sbox = 8'h7b;
      8'h22: inv_sbox = 8'h94;
      8'h23: inv_sbox = 8'h32;
      8'h24: inv_sbox = 8'ha6;
      8'h25: inv_sbox = 8'hc2;
      8'h26: inv_sbox = 8'h23;
      8'h27: inv_sbox = 8'h3d;
      8'h28: inv_sbox = 8'hee;
      8'h29: inv_sbox = 8'h4c;
      8'h2a: inv_sbox = 8'h95;
      8'h2b: inv_sbox = 8'h0b;
      8'h2c: inv_sbox = 8'h42;
      8'h2d: inv_sbox = 8'hfa;
      8'h2e: inv_sbox = 8'hc3;
      8'h2f: inv_sbox = 8'h4e;
      8'h30: inv_sbox = 8'h08;
      8'h31: inv_sbox = 8'h2e;
      8'h32: inv_sbox = 8'ha1;
      8'h33: inv_sbox = 8'h66;
      8'h34: inv_sbox = 8'h28;
      8'h35: inv_sbox = 8'hd9;
      8'h36: inv_sbox = 8'h24;
      8'h37: inv_sbox = 8'hb2;
      8'h38: inv_sbox = 8'h76;
      8'h39: inv_sbox = 8'h5b;
      8'h3a: inv_sbox = 8'ha2;
      8'h3b: inv_sbox = 8'h49;
      8'h3c: inv_sbox = 8'h6d;
      8'h3d: inv_sbox = 8'h8b;
      8'h3e: inv_sbox = 8'hd1;
      8'h3f: inv_sbox = 8'h25;
      8'h40: inv_sbox = 8'h72;
      8'h41: inv_sbox = 8'hf8;
      8'h42: inv_sbox = 8'hf6;
      8'h43: inv_sbox = 8'h64;
      8'h44: inv_sbox = 8'h86;
      8'h45: inv_sbox = 8'h68;
      8'h46: inv_sbox = 8'h98;
      8'h47: inv_sbox = 8'h16;
      8'h48: inv_sbox = 8'hd4;
      8'h49: inv_sbox = 8'ha4;
      8'h4a: inv_sbox = 8'h5c;
      8'h4b: inv_sbox = 8'hcc;
      8'h4c: inv_sbox = 8'h5d;
      8'h4d: inv_sbox = 8'h65;
      8'h4e: inv_sbox = 8'hb6;
      8'h4f: inv_sbox = 8'h92;
      8'h50: inv_sbox = 8'h6c;
      8'h51: inv_sbox = 8'h70;
      8'h52: inv_sbox = 8'h48;
      8'h53: inv_sbox = 8'h50;
      8'h54: inv_sbox = 8'hfd;
      8'h55: inv_sbox = 8'hed;
      8'h56: inv_sbox = 8'hb9;
      8'h57: inv_sbox = 8'hda;
      8'h58: inv_sbox = 8'h5e;
      8'h59: inv_sbox = 8'h15;
      8'h5a: inv_sbox = 8'h46;
      8'h5b: inv_sbox = 8'h57;
      8'h5c: inv_sbox = 8'ha7;
      8'h5d: inv_sbox = 8'h8d;
      8'h5e: inv_sbox = 8'h9d;
      8'h5f: inv_sbox = 8'h84;
      8'h60: inv_sbox = 8'h90;
      8'h61: inv_sbox = 8'hd8;
      8'h62: inv_sbox = 8'hab;
      8'h63: inv_sbox = 8'h00;
      8'h64: inv_sbox = 8'h8c;
      8'h65: inv_sbox = 8'hbc;
      8'h66: inv_sbox = 8'hd3;
      8'h67: inv_sbox = 8'h0a;
      8'h68: inv_sbox = 8'hf7;
      8'h69: inv_sbox = 8'he4;
      8'h6a: inv_sbox = 8'h58;
      8'h6b: inv_sbox = 8'h05;
      8'h6c: inv_sbox = 8'hb8;
      8'h6d: inv_sbox = 8'hb3;
      8'h6e: inv_sbox = 8'h45;
      8'h6f: inv_sbox = 8'h06;
      8'h70: inv_sbox = 8'hd0;
      8'h71: inv_sbox = 8'h2c;
      8'h72: inv_sbox = 8'h1e;
      8'h73: inv_sbox = 8'h8f;
      8'h74: inv_sbox = 8'hca;
      8'h75: inv_sbox = 8'h3f;
      8'h76: inv_sbox = 8'h0f;
      8'h77: inv_sbox = 8'h02;
      8'h78: inv_sbox = 8'hc1;
      8'h79: inv_sbox = 8'haf;
      8'h7a: inv_sbox = 8'hbd;
      8'h7b: inv_sbox = 8'h03;
      8'h7c: inv_sbox = 8'h01;
      8'h7d: inv_sbox = 8'h13;
      8'h7e: inv_sbox = 8'h8a;
      8'h7f: inv_sbox = 8'h6b;
      8'h80: inv_sbox = 8'h3a;
      8'h81: inv_sbox = 8'h91;
      8'h82: inv_sbox = 8'h11;
      8'h83: inv_sbox = 8'h41;
      8'h84: inv_sbox = 8'h4f;
      8'h85: inv_sbox = 8'h67;
      8'h86: inv_sbox = 8'hdc;
      8'h87: inv_sbox = 8'hea;
      8'h88: inv_sbox = 8'h97;
      8'h89: inv_sbox = 8'hf2;
      8'h8a: inv_sbox = 8'hcf;
      8'h8b: inv_sbox = 8'hce;
      8'h8c: inv_sbox = 8'hf0;
      8'h8d: inv_sbox = 8'hb4;
      8'h8e: inv_sbox = 8'he6;
      8'h8f: inv_sbox = 8'h73;
      8'h90: inv_sbox = 8'h96;
      8'h91: inv_sbox = 8'hac;
      8'h92: inv_sbox = 8'h74;
      8'h93: inv_sbox = 8'h22;
      8'h94: inv_sbox = 8'he7;
      8'h95: inv_sbox = 8'had;
      8'h96: inv_sbox = 8'h35;
      8'h97: inv_sbox = 8'h85;
      8'h98: inv_sbox = 8'he2;
      8'h99: inv_sbox = 8'hf9;
      8'h9a: inv_sbox = 8'h37;
      8'h9b: inv_sbox = 8'he8;
      8'h9c: inv_sbox = 8'h1c;
      8'h9d: inv_sbox = 8'h75;
      8'h9e: inv_sbox = 8'hdf;
      8'h9f: inv_sbox = 8'h6e;
      8'ha0: inv_sbox = 8'h47;
      8'ha1: inv_sbox = 8'hf1;
      8'ha2: inv_sbox = 8'h1a;
      8'ha3: inv_sbox = 8'h71;
      8'ha4: inv_sbox = 8'h1d;
      8'ha5: inv_sbox = 8'h29;
      8'ha6: inv_sbox = 8'hc5;
      8'ha7: inv_sbox = 8'h89;
      8'ha8: inv_sbox = 8'h6f;
      8'ha9: inv_sbox = 8'hb7;
      8'haa: inv_sbox = 8'h62;
      8'hab: inv_sbox = 8'h0e;
      8'hac: inv_sbox = 8'haa;
      8'had: inv_sbox = 8'h18;
      8'hae: inv_sbox = 8'hbe;
      8'haf: inv_sbox = 8'h1b;
      8'hb0: inv_sbox = 8'hfc;
      8'hb1: inv_sbox = 8'h56;
      8'hb2: inv_sbox = 8'h3e;
      8'hb3: inv_sbox = 8'h4b;
      8'hb4: inv_sbox = 8'hc6;
      8'hb5: inv_sbox = 8'hd2;
      8'hb6: inv_sbox = 8'h79;
      8'hb7: inv_sbox = 8'h20;
      8'hb8: inv_sbox = 8'h9a;
      8'hb9: inv_sbox = 8'hdb;
      8'hba: inv_sbox = 8'hc0;
      8'hbb: inv_sbox = 8'hfe;
      8'hbc: inv_sbox = 8'h78;
      8'hbd: inv_sbox = 8'hcd;
      8'hbe: inv_sbox = 8'h5a;
      8'hbf: inv_sbox = 8'hf4;
      8'hc0: inv_sbox = 8'h1f;
      8'hc1: inv_sbox = 8'hdd;
      8'hc2: inv_sbox = 8'ha8;
      8'hc3: inv_sbox = 8'h33;
      8'hc4: inv_sbox = 8'h88;
      8'hc5: inv_sbox = 8'h07;
      8'hc6: inv_sbox = 8'hc7;
      8'hc7: inv_sbox = 8'h31;
      8'hc8: inv_sbox = 8'hb1;
      8'hc9: inv_sbox = 8'h12;
      8'hca: inv_sbox = 8'h10;
      8'hcb: inv_sbox = 8'h59;
      8'hcc: inv_sbox = 8'h27;
      8'hcd: inv_sbox = 8'h80;
      8'hce: inv_sbox = 8'hec;
      8'hcf: inv_sbox = 8'h5f;
      8'hd0: inv_sbox = 8'h60;
      8'hd1: inv_sbox = 8'h51;
      8'hd2: inv_sbox = 8'h7f;
      8'hd3: inv_sbox = 8'ha9;
      8'hd4: inv_sbox = 8'h19;
      8'hd5: inv_sbox = 8'hb5;
      8'hd6: inv_sbox = 8'h4a;
      8'hd7: inv_sbox = 8'h0d;
      8'hd8: inv_sbox = 8'h2d;
      8'hd9: inv_sbox = 8'he5;
      8'hda: inv_sbox = 8'h7a;
      8'hdb: inv_sbox = 8'h9f;
      8'hdc: inv_sbox = 8'h93;
      8'hdd: inv_sbox = 8'hc9;
      8'hde: inv_sbox = 8'h9c;
      8'hdf: inv_sbox = 8'hef;
      8'he0: inv_sbox = 8'ha0;
      8'he1: inv_sbox = 8'he0;
      8'he2: inv_sbox = 8'h3b;
      8'he3: inv_sbox = 8'h4d;
      8'he4: inv_sbox = 8'hae;
      8'he5: inv_sbox = 8'h2a;
      8'he6: inv_sbox = 8'hf5;
      8'he7: inv_sbox = 8'hb0;
      8'he8: inv_sbox = 8'hc8;
      8'he9: inv_sbox = 8'heb;
      8'hea: inv_sbox = 8'hbb;
      8'heb: inv_sbox = 8'h3c;
      8'hec: inv_sbox = 8'h83;
      8'hed: inv_sbox = 8'h53;
      8'hee: inv_sbox = 8'h99;
      8'hef: inv_sbox = 8'h61;
      8'hf0: inv_sbox = 8'h17;
      8'hf1: inv_sbox = 8'h2b;
      8'hf2: inv_sbox = 8'h04;
      8'hf3: inv_sbox = 8'h7e;
      8'hf4: inv_sbox = 8'hba;
      8'hf5: inv_sbox = 8'h77;
      8'hf6: inv_sbox = 8'hd6;
      8'hf7: inv_sbox = 8'h26;
      8'hf8: inv_sbox = 8'he1;
      8'hf9: inv_sbox = 8'h69;
      8'hfa: inv_sbox = 8'h14;
      8'hfb: inv_sbox = 8'h63;
      8'hfc: inv_sbox = 8'h55;
      8'hfd: inv_sbox = 8'h21;
      8'hfe: inv_sbox = 8'h0c;
      8'hff: inv_sbox = 8'h7d;
      default: inv_sbox = 8'h00;
    endcase
  endfunction

  // Select the current column, substitute its four bytes, splice it back.
  always_comb begin
    col_in_s  = st_r[127:96];
    st_next_s = st_r;
    case (col_r)
      2'd0:    col_in_s = st_r[127:96];
      2'd1:    col_in_s = st_r[95:64];
      2'd2:    col_in_s = st_r[63:32];
      2'd3:    col_in_s = st_r[31:0];
      default: col_in_s = st_r[127:96];
    endcase
    col_sub_s = {inv_sbox(col_in_s[31:24]), inv_sbox(col_in_s[23:16]),
                 inv_sbox(col_in_s[15:8]),  inv_sbox(col_in_s[7:0])};
    case (col_r)
      2'd0:    st_next_s[127:96] = col_sub_s;
      2'd1:    st_next_s[95:64]  = col_sub_s;
      2'd2:    st_next_s[63:32]  = col_sub_s;
      2'd3:    st_next_s[31:0]   = col_sub_s;
      default: st_next_s         = st_r;
    endcase
  end

  // Control FSM, state register and column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      st_r    <= {LENGTH{1'b0}};
      col_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            st_r    <= in_data;
            col_r   <= 2'd0;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          st_r  <= st_next_s;
          col_r <= col_r + 2'd1;
          if (col_r == 2'd3) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          col_r   <= 2'd0;
        end
      endcase
    end
  end

  // Handshake flags depend only on the FSM register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == BUSY) || (state_r == DONE);
  assign out_data  = st_r;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed and table-driven bench for inv_sub_bytes; the reference is the
// FIPS-197 forward S-box, with its inverse derived inside the bench.
module tb_inv_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks;
  int errors;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] fsbox [0:255];
  logic [7:0] invtab [0:255];

  inv_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] fwd(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fsbox[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = invtab[d[8*i +: 8]];
    return r;
  endfunction

  // One block: accept, time the latency, optionally stall in DONE, release.
  task automatic run_block(input logic [127:0] din, input logic [127:0] exp,
                           input int stall, input bit poke, input string nm);
    int n;
    int bad;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " ready"}, in_ready, 1'b1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~din;
    n   = 0;
    bad = 0;
    while (!out_valid && n < 20) begin
      if (in_ready || !busy) bad++;
      @(posedge clk); #1; n++;
    end
    // acceptance edge ends cycle T; out_valid appears in T+5, four edges later
    chk({nm, " latency"}, n, 4);
    chk({nm, " busy flags"}, bad, 0);
    chk({nm, " data"}, out_data, exp);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid = i[0];
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      chk({nm, " hold data"}, out_data, exp);
      chk({nm, " hold flags"}, {in_ready, out_valid, busy}, 3'b011);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " back to idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    logic [127:0] din;
    logic [127:0] got [$];
    int           acc [$];
    int           nxt;
    int           seen;

    checks = 0;
    errors = 0;
    fsbox = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    for (int x = 0; x < 256; x++) invtab[fsbox[x]] = x[7:0];

    vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[1] = '{128'h0,                                 {16{8'h52}}};
    vecs[2] = '{{16{8'h16}},                            {16{8'hff}}};
    vecs[3] = '{128'hca82c97dfa5947f0add4a2af9ca472c0, 128'h101112131415161718191a1b1c1d1e1f};
    vecs[4] = '{{16{8'h63}},                            {16{8'h00}}};
    vecs[5] = '{{16{8'h7c}},                            {16{8'h01}}};
    vecs[6] = '{{16{8'h52}},                            {16{8'h48}}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'h0;
    out_ready = 1'b0;
    #23;
    chk("reset flags", {in_ready, out_valid, busy}, 3'b100);
    chk("reset data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_block(vecs[i].din, vecs[i].exp, 0, 1'b0, $sformatf("vec%0d", i));

    run_block(vecs[0].din, vecs[0].exp, 10, 1'b1, "backpressure");

    // Reset landing in the second BUSY cycle discards the block.
    in_valid = 1'b1;
    in_data  = vecs[3].din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midbusy reset flags", {in_ready, out_valid, busy}, 3'b100);
    chk("midbusy reset data", out_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no output after reset", seen, 0);
    run_block(vecs[3].din, vecs[3].exp, 0, 1'b0, "after reset");

    for (int k = 0; k < 64; k++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          din[127 - 8*(4*c + j) -: 8] = 8'((4*k + c + 64*j) % 256);
      run_block(din, inv_model(din), $urandom_range(0, 3), 1'b0, $sformatf("exh%0d", k));
      chk($sformatf("exh%0d roundtrip", k), fwd(out_data), din);
    end

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    nxt = 0;
    for (int cyc = 0; cyc < 60 && got.size() < 4; cyc++) begin
      if (out_valid) got.push_back(out_data);
      if (in_ready) begin
        if (nxt < 4) begin
          in_data = vecs[nxt].din;
          acc.push_back(cyc);
          nxt++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b count", got.size(), 4);
    chk("b2b accepts", acc.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("b2b out%0d", i), got[i], vecs[i].exp);
    for (int i = 1; i < acc.size(); i++)
      chk($sformatf("b2b spacing%0d", i), acc[i] - acc[i-1], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
